dff_reg_arbiter: RTL and testbench
==================================

# dff_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit register, built from sync D flip-flops, among NREQ requesters. Each requester raises `req` with its write data. The arbiter grants one requester at a time, loads that requester's data into the shared register, and acknowledges. It sits between the workshop's requester blocks and the shared register bank, so the flip-flop datapath has exactly one writer per transaction.

## Interface
- `WIDTH`, 8, width of shared register and of each write-data lane
- `NREQ`, 4, number of requesters (2..8)
- `OW`, $clog2(NREQ), width of `owner`

- `CLK`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; asserted when 0
- `req`  in  NREQ  request per requester; held until `ack` or abandoned
- `wdata`  in  NREQ*WIDTH  packed write data; lane i = `wdata[i*WIDTH +: WIDTH]`
- `gnt`  out  NREQ  one-hot grant, registered
- `ack`  out  NREQ  one-hot, one-cycle completion pulse, registered
- `q`  out  WIDTH  shared register contents
- `owner`  out  OW  index of current or most recent grantee
- `busy`  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, GRANT, ACK.
- **IDLE:**
  - If `req` != 0, pick the winner by round-robin, searching from `last+1` upward and wrapping at NREQ.
  - Go to GRANT with `gnt[winner]`=1 and `owner`=winner.
  - If `req` == 0, stay in IDLE.
- **GRANT (one cycle):**
  - If `req[owner]`=1: `q <= wdata[owner]`, `last <= owner`, go to ACK.
  - If `req[owner]`=0 (abandoned): no load, `last` unchanged, go to IDLE.
  - `gnt` clears on exit in both cases.
- **ACK (one cycle):** `ack[owner]`=1, then IDLE.
  - A requester wanting no further write drops `req` during ACK.
  - If `req` is still high in the next IDLE cycle, it competes again at lowest priority.
- `q` changes only on the GRANT→ACK edge; it holds its value otherwise.
- Requests arriving during GRANT/ACK wait; there is no preemption.
- `req` bits for indices ≥ NREQ do not exist; `wdata` is lane-aligned and not checked.
- **Reset (any state, mid-transaction included):**
  - state=IDLE, `gnt`=0, `ack`=0, `q`=0, `owner`=0, `busy`=0.
  - `last`=NREQ-1, so requester 0 has highest priority after reset.
  - An in-flight GRANT is discarded with no load and no ack.

## Timing
- Request seen in IDLE at edge n → `gnt` high during cycle n+1 → `q` updated and `ack` high during cycle n+2 → IDLE during cycle n+3.
- Minimum transaction length is 3 cycles. Back-to-back throughput is one write per 3 cycles.
- `wdata[owner]` is sampled at the GRANT→ACK edge. It must be stable during the GRANT cycle only.
- All outputs are registered; no combinational path from `req` to `gnt` or `ack`.
- Reset is asynchronous assert; deassertion is synchronized externally.

## Structure
- Shared package `dff_arb_pkg`:
  - state typedef: IDLE=2'd0, GRANT=2'd1, ACK=2'd2 (2'd3 is illegal and recovers to IDLE)
  - default `WIDTH`/`NREQ` constants
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `win`, index `win_idx`, `any`.
- The top holds the FSM, `last`, `owner`, the `q` register and output registers.

## Test plan
1. Reset values:
   - Drive `reset`=0 mid-GRANT with `req`=4'b0010.
   - Required: `gnt`=0, `ack`=0, `q`=0, `busy`=0 immediately; no ack after release.
2. Single requester:
   - After reset, `req`=4'b0100 with lane 2 = 8'hA5.
   - Required: `gnt`=4'b0100 at n+1; `q`=8'hA5 and `ack`=4'b0100 at n+2; `busy` low at n+3.
3. Full contention:
   - `req`=4'b1111 held, lanes = 8'h10, 8'h11, 8'h12, 8'h13.
   - Required: grant order 0,1,2,3,0, one ack every 3 cycles; `q` follows 10,11,12,13,10.
4. Abandon:
   - Requester 1 granted, then drops `req` during GRANT.
   - Required: no `ack`, `q` unchanged, return to IDLE.
   - Next contention with `req`=4'b0011 grants requester 1 first, since `last` was not updated by the abandoned grant.
5. Fairness:
   - `req[0]` held high continuously; `req[3]` raised at cycle 5.
   - Required: grants alternate 0,3,0,3; requester 3 waits at most one transaction.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// The state encoding is a plain 2-bit vector so 2'd3 stays representable and can be recovered from.
package dff_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t GRANT = 2'd1;
    localparam arb_state_t ACK   = 2'd2;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NREQ  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester above `last`, wrapping at NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [OW-1:0]   win_idx,
    output logic            any
);

    int unsigned idx;

    // Offsets run 1..NREQ, so `last` itself is checked last (lowest priority).
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!any && req[idx[OW-1:0]]) begin
                any               = 1'b1;
                win[idx[OW-1:0]]  = 1'b1;
                win_idx           = idx[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared register.
// Each transaction is GRANT then ACK; the register loads only on the GRANT->ACK edge.
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned OW    = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [OW-1:0]         owner,
    output logic                  busy
);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_q, last_d;
    logic             busy_q;

    logic [NREQ-1:0]  pick_win;
    logic [OW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_rr_pick (
        .req     (req),
        .last    (last_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_win;
                    owner_d = pick_idx;
                end
            end
            GRANT: begin
                // A dropped request abandons the grant without touching q or last.
                if (req[owner_q]) begin
                    q_d            = wdata[owner_q*WIDTH +: WIDTH];
                    last_d         = owner_q;
                    ack_d[owner_q] = 1'b1;
                    state_d        = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter: transaction-level model checked every cycle,
// plus directed literal expectations for reset, single write, contention, abandon and fairness.
module tb_dff_reg_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned OW    = 2;

    logic                  CLK;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [OW-1:0]         owner;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;

    dff_reg_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .OW    (OW)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: phase 0 = waiting, 1 = someone holds the grant, 2 = write acknowledged.
    int               m_phase;
    int               m_last;
    int               m_owner;
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_gnt;
    logic [NREQ-1:0]  m_ack;

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_last  <= NREQ - 1;
            m_owner <= 0;
            m_q     <= '0;
            m_gnt   <= '0;
            m_ack   <= '0;
        end else begin
            m_gnt <= '0;
            m_ack <= '0;
            if (m_phase == 0) begin
                if (rr_winner(req, m_last) >= 0) begin
                    m_owner <= rr_winner(req, m_last);
                    m_gnt   <= NREQ'(1) << rr_winner(req, m_last);
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (req[m_owner]) begin
                    m_q     <= wdata[m_owner*WIDTH +: WIDTH];
                    m_last  <= m_owner;
                    m_ack   <= NREQ'(1) << m_owner;
                    m_phase <= 2;
                end else begin
                    m_phase <= 0;
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("model_gnt",   32'(gnt),   32'(m_gnt));
        chk("model_ack",   32'(ack),   32'(m_ack));
        chk("model_q",     32'(q),     32'(m_q));
        chk("model_owner", 32'(owner), 32'(m_owner));
        chk("model_busy",  32'(busy),  32'(m_phase != 0));
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        wdata = '0;
        repeat (2) @(negedge CLK);
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        chk("rst_q",     32'(q),     32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        reset = 1'b1;
        @(negedge CLK);

        // Reset asserted while requester 1 holds the grant
        req = 4'b0010;
        @(negedge CLK);
        chk("t1_gnt", 32'(gnt), 32'h2);
        #2 reset = 1'b0;
        #1;
        chk("t1_rst_gnt",  32'(gnt),  32'h0);
        chk("t1_rst_ack",  32'(ack),  32'h0);
        chk("t1_rst_q",    32'(q),    32'h0);
        chk("t1_rst_busy", 32'(busy), 32'h0);
        req = '0;
        @(negedge CLK);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t1_no_ack", 32'(ack), 32'h0);
        end

        // Single requester
        wdata = 32'h00A5_0000;
        req   = 4'b0100;
        @(negedge CLK);
        chk("t2_gnt",  32'(gnt),  32'h4);
        chk("t2_busy", 32'(busy), 32'h1);
        @(negedge CLK);
        chk("t2_q",   32'(q),   32'hA5);
        chk("t2_ack", 32'(ack), 32'h4);
        req = '0;
        @(negedge CLK);
        chk("t2_idle", 32'(busy), 32'h0);

        // Full contention from a fresh reset
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        wdata = 32'h1312_1110;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t3_gnt", 32'(gnt), 32'(1 << (i % 4)));
            @(negedge CLK);
            chk("t3_ack", 32'(ack), 32'(1 << (i % 4)));
            chk("t3_q",   32'(q),   32'h10 + 32'(i % 4));
            if (i == 4) req = '0;
            @(negedge CLK);
            chk("t3_gap", 32'(busy), 32'h0);
        end

        // Abandon: requester 1 drops its request during GRANT
        req = 4'b0010;
        @(negedge CLK);
        chk("t4_gnt", 32'(gnt), 32'h2);
        req = '0;
        @(negedge CLK);
        chk("t4_ack",  32'(ack),  32'h0);
        chk("t4_q",    32'(q),    32'h10);
        chk("t4_busy", 32'(busy), 32'h0);
        req = 4'b0011;
        @(negedge CLK);
        chk("t4_regnt", 32'(gnt), 32'h2);
        @(negedge CLK);
        chk("t4_reack", 32'(ack), 32'h2);
        chk("t4_req",   32'(q),   32'h11);
        req = '0;
        @(negedge CLK);

        // Fairness: req[0] held, req[3] joins at cycle 5
        wdata = 32'h2300_0020;
        req   = 4'b0001;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            if (c == 5) req = 4'b1001;
            case (c)
                1, 4, 10, 16: chk("t5_gnt0", 32'(gnt), 32'h1);
                7, 13:        chk("t5_gnt3", 32'(gnt), 32'h8);
                8: begin
                    chk("t5_ack3", 32'(ack), 32'h8);
                    chk("t5_q3",   32'(q),   32'h23);
                end
                default: ;
            endcase
        end
        req = '0;
        repeat (4) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
